// File: rtl/riscv_enc_pkg.sv
// Shared definitions for the RV64 instruction encoder: format codes,
// common opcodes, the NOP word and the legal immediate ranges per format.
package riscv_enc_pkg;

   localparam int INSTR_W = 32;
   localparam int IMM_W   = 64;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_BAD6 = 3'd6,
      FMT_BAD7 = 3'd7
   } fmt_e;

   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   // addi x0, x0, 0 -- substituted for any word that cannot be encoded
   localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;

   // Inclusive signed bounds on the full-width immediate
   localparam logic signed [IMM_W-1:0] IMM12_MIN = -64'sd2048;
   localparam logic signed [IMM_W-1:0] IMM12_MAX =  64'sd2047;
   localparam logic signed [IMM_W-1:0] IMMB_MIN  = -64'sd4096;
   localparam logic signed [IMM_W-1:0] IMMB_MAX  =  64'sd4094;
   localparam logic signed [IMM_W-1:0] IMMJ_MIN  = -64'sd1048576;
   localparam logic signed [IMM_W-1:0] IMMJ_MAX  =  64'sd1048574;
   localparam logic signed [IMM_W-1:0] IMMU_MIN  = -64'sd2147483648;
   localparam logic signed [IMM_W-1:0] IMMU_MAX  =  64'sd2147483647;

   function automatic logic in_range(input logic signed [IMM_W-1:0] v,
                                     input logic signed [IMM_W-1:0] lo,
                                     input logic signed [IMM_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/instruction_encoder_packer.sv
// Combinational field packer: turns one field bundle into a 32-bit RISC-V
// word, or the NOP word plus an error flag when the immediate is out of
// range, misaligned, or the format code is illegal.
module instruction_packer
   import riscv_enc_pkg::*;
#(
   parameter int IMMSIZE = 64
) (
   input  logic [2:0]         i_fmt,
   input  logic [6:0]         i_opcode,
   input  logic [2:0]         i_funct3,
   input  logic [6:0]         i_funct7,
   input  logic [4:0]         i_rd,
   input  logic [4:0]         i_rs1,
   input  logic [4:0]         i_rs2,
   input  logic [IMMSIZE-1:0] i_imm,
   output logic [INSTR_W-1:0] o_word,
   output logic               o_error
);

   // Sign-extended view of the immediate used for every range test
   logic signed [IMM_W-1:0] w_imm;
   logic [INSTR_W-1:0]      w_word;
   logic                    w_err;

   assign w_imm = IMM_W'($signed(i_imm));

   // Per-format packing and legality; a fault forces the NOP word
   always_comb begin
      w_word = NOP_WORD;
      w_err  = 1'b0;
      case (i_fmt)
         FMT_R: begin
            w_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
         end
         FMT_I: begin
            w_err  = !in_range(w_imm, IMM12_MIN, IMM12_MAX);
            w_word = {w_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
         end
         FMT_S: begin
            w_err  = !in_range(w_imm, IMM12_MIN, IMM12_MAX);
            w_word = {w_imm[11:5], i_rs2, i_rs1, i_funct3, w_imm[4:0], i_opcode};
         end
         FMT_B: begin
            w_err  = w_imm[0] || !in_range(w_imm, IMMB_MIN, IMMB_MAX);
            w_word = {w_imm[12], w_imm[10:5], i_rs2, i_rs1, i_funct3,
                      w_imm[4:1], w_imm[11], i_opcode};
         end
         FMT_U: begin
            w_err  = (w_imm[11:0] != 12'd0) || !in_range(w_imm, IMMU_MIN, IMMU_MAX);
            w_word = {w_imm[31:12], i_rd, i_opcode};
         end
         FMT_J: begin
            w_err  = w_imm[0] || !in_range(w_imm, IMMJ_MIN, IMMJ_MAX);
            w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_rd, i_opcode};
         end
         default: begin
            w_err = 1'b1;
         end
      endcase
      if (w_err) begin
         w_word = NOP_WORD;
      end
   end

   assign o_word  = w_word;
   assign o_error = w_err;

endmodule

// File: rtl/instruction_encoder.sv
// Two-stage pipelined RV64 instruction encoder. Stage 1 captures the field
// bundle, the packer encodes it, stage 2 holds the word for the consumer.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds in_* stable while in_valid & ~in_ready; this
// block holds out_instruction/out_error stable while out_valid & ~out_ready.
// in_ready depends only on internal state and out_ready, never on in_valid.
module instruction_encoder
   import riscv_enc_pkg::*;
#(
   parameter int INSTRSIZE = 32,
   parameter int IMMSIZE   = 64,
   parameter int CNTSIZE   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_fmt,
   input  logic [6:0]           in_opcode,
   input  logic [2:0]           in_funct3,
   input  logic [6:0]           in_funct7,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [IMMSIZE-1:0]   in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INSTRSIZE-1:0] out_instruction,
   output logic                 out_error,
   output logic [CNTSIZE-1:0]   enc_count
);

   logic               r_s1_valid;
   logic [2:0]         r_s1_fmt;
   logic [6:0]         r_s1_opcode;
   logic [2:0]         r_s1_funct3;
   logic [6:0]         r_s1_funct7;
   logic [4:0]         r_s1_rd;
   logic [4:0]         r_s1_rs1;
   logic [4:0]         r_s1_rs2;
   logic [IMMSIZE-1:0] r_s1_imm;

   logic                 r_out_valid;
   logic [INSTRSIZE-1:0] r_out_instr;
   logic                 r_out_err;
   logic [CNTSIZE-1:0]   r_enc_count;

   logic               w_adv2;
   logic               w_in_ready;
   logic [INSTR_W-1:0] w_pack_word;
   logic               w_pack_err;

   // Stage 2 may load whenever its word is absent or leaving this cycle
   assign w_adv2     = !r_out_valid || out_ready;
   assign w_in_ready = !r_s1_valid || w_adv2;

   // Stage 1: capture the bundle; holds while stage 2 is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_fmt    <= 3'd0;
         r_s1_opcode <= 7'd0;
         r_s1_funct3 <= 3'd0;
         r_s1_funct7 <= 7'd0;
         r_s1_rd     <= 5'd0;
         r_s1_rs1    <= 5'd0;
         r_s1_rs2    <= 5'd0;
         r_s1_imm    <= '0;
      end else if (w_in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_fmt    <= in_fmt;
            r_s1_opcode <= in_opcode;
            r_s1_funct3 <= in_funct3;
            r_s1_funct7 <= in_funct7;
            r_s1_rd     <= in_rd;
            r_s1_rs1    <= in_rs1;
            r_s1_rs2    <= in_rs2;
            r_s1_imm    <= in_imm;
         end
      end
   end

   instruction_packer #(
      .IMMSIZE (IMMSIZE)
   ) u_packer (
      .i_fmt    (r_s1_fmt),
      .i_opcode (r_s1_opcode),
      .i_funct3 (r_s1_funct3),
      .i_funct7 (r_s1_funct7),
      .i_rd     (r_s1_rd),
      .i_rs1    (r_s1_rs1),
      .i_rs2    (r_s1_rs2),
      .i_imm    (r_s1_imm),
      .o_word   (w_pack_word),
      .o_error  (w_pack_err)
   );

   // Stage 2: register the encoded word; frozen while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_out_err   <= 1'b0;
      end else if (w_adv2) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_instr <= INSTRSIZE'(w_pack_word);
            r_out_err   <= w_pack_err;
         end
      end
   end

   // Count completed output handshakes, wrapping at the counter width
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enc_count <= '0;
      end else if (r_out_valid && out_ready) begin
         r_enc_count <= r_enc_count + CNTSIZE'(1);
      end
   end

   assign in_ready        = w_in_ready;
   assign out_valid       = r_out_valid;
   assign out_instruction = r_out_instr;
   assign out_error       = r_out_err;
   assign enc_count       = r_enc_count;

endmodule
